dmem_miss_ctrl: RTL and testbench

// Sequences data-memory accesses from the decoder (DMRead/DMWrite) through the set-associative

---
 rtl/dmem_miss_ctrl.sv | 175 +++++++++++++++++
 tb/tb_dmem_miss_ctrl.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_miss_ctrl.sv
// ============================================================================
// Module   : dmem_miss_ctrl
// Brief    : Data-cache miss sequencer: lookup, dirty write-back, refill, retry.
// Revision : 1.0
// ============================================================================
`default_nettype none

module dmem_miss_ctrl #(
    parameter int ADDR_W    = 16,
    parameter int DATA_W    = 32,
    parameter int BLK_WORDS = 4,
    parameter int SET_W     = 4,
    localparam int WB_W     = $clog2(BLK_WORDS),
    localparam int TAG_W    = ADDR_W - SET_W - WB_W - 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              dm_read,
    input  logic              dm_write,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              cache_hit,
    input  logic              victim_dirty,
    input  logic [TAG_W-1:0]  victim_tag,
    output logic              stall,
    output logic [ADDR_W-1:0] lat_addr,
    output logic              rd_valid,
    output logic              cache_we,
    output logic [DATA_W-1:0] cache_wdata,
    output logic              fill_we,
    output logic [WB_W-1:0]   fill_idx,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    output logic              err,
    output logic [15:0]       miss_count
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOOKUP = 3'd1,
        S_WB     = 3'd2,
        S_FILL   = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    localparam logic [WB_W-1:0] c_LAST = WB_W'(BLK_WORDS - 1);
    localparam logic [WB_W-1:0] c_ONE  = WB_W'(1);

    state_t              r_state;
    logic [WB_W-1:0]     r_cnt;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic                r_is_write;
    logic                r_refilled;
    logic                r_err;
    logic [15:0]         r_miss_count;

    logic                w_accept;
    logic                w_last;
    logic [TAG_W-1:0]    w_tag;
    logic [SET_W-1:0]    w_set;

    assign w_accept = (r_state == S_IDLE) && (dm_read || dm_write);
    assign w_last   = (r_cnt == c_LAST);
    assign w_tag    = r_addr[ADDR_W-1 -: TAG_W];
    assign w_set    = r_addr[WB_W+2 +: SET_W];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_is_write   <= 1'b0;
            r_refilled   <= 1'b0;
            r_err        <= 1'b0;
            r_miss_count <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_addr     <= addr;
                        r_wdata    <= wdata;
                        r_is_write <= dm_write;
                        r_state    <= S_LOOKUP;
                    end
                end
                S_LOOKUP: begin
                    if (cache_hit) begin
                        r_state <= S_DONE;
                    end else if (r_refilled) begin
                        // A miss right after our own refill means the cache lost the block.
                        r_err   <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        if (r_miss_count != 16'hFFFF)
                            r_miss_count <= r_miss_count + 16'd1;
                        r_cnt   <= '0;
                        r_state <= victim_dirty ? S_WB : S_FILL;
                    end
                end
                S_WB: begin
                    if (mem_ack) begin
                        if (w_last) begin
                            r_cnt   <= '0;
                            r_state <= S_FILL;
                        end else begin
                            r_cnt <= r_cnt + c_ONE;
                        end
                    end
                end
                S_FILL: begin
                    if (mem_ack) begin
                        if (w_last) begin
                            r_cnt      <= '0;
                            r_refilled <= 1'b1;
                            r_state    <= S_LOOKUP;
                        end else begin
                            r_cnt <= r_cnt + c_ONE;
                        end
                    end
                end
                S_DONE: begin
                    r_refilled <= 1'b0;
                    r_state    <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Access pulses depend on the live tag compare for the latched address.
    always_comb begin
        stall    = w_accept;
        rd_valid = 1'b0;
        cache_we = 1'b0;
        fill_we  = 1'b0;
        fill_idx = '0;
        mem_req  = 1'b0;
        mem_we   = 1'b0;
        mem_addr = '0;
        case (r_state)
            S_LOOKUP: begin
                stall    = 1'b1;
                rd_valid = cache_hit && !r_is_write;
                cache_we = cache_hit && r_is_write;
            end
            S_WB: begin
                stall    = 1'b1;
                mem_req  = 1'b1;
                mem_we   = 1'b1;
                mem_addr = {victim_tag, w_set, r_cnt, 2'b00};
                fill_idx = r_cnt;
            end
            S_FILL: begin
                stall    = 1'b1;
                mem_req  = 1'b1;
                mem_addr = {w_tag, w_set, r_cnt, 2'b00};
                fill_idx = r_cnt;
                fill_we  = mem_ack;
            end
            default: ;
        endcase
    end

    assign lat_addr    = r_addr;
    assign cache_wdata = r_wdata;
    assign err         = r_err;
    assign miss_count  = r_miss_count;

endmodule

`default_nettype wire

// File: tb/tb_dmem_miss_ctrl.sv
// ============================================================================
// Module   : tb_dmem_miss_ctrl
// Brief    : Scoreboard bench for dmem_miss_ctrl with a 2-cycle-latency memory.
// Revision : 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_dmem_miss_ctrl;

    localparam int c_ADDR_W = 16;
    localparam int c_DATA_W = 32;

    localparam int K_RD  = 0;
    localparam int K_WR  = 1;
    localparam int K_MRD = 2;
    localparam int K_MWB = 3;
    localparam int K_FIL = 4;

    logic                clk;
    logic                rst_n;
    logic                dm_read;
    logic                dm_write;
    logic [c_ADDR_W-1:0] addr;
    logic [c_DATA_W-1:0] wdata;
    logic                cache_hit;
    logic                victim_dirty;
    logic [7:0]          victim_tag;
    logic                stall;
    logic [c_ADDR_W-1:0] lat_addr;
    logic                rd_valid;
    logic                cache_we;
    logic [c_DATA_W-1:0] cache_wdata;
    logic                fill_we;
    logic [1:0]          fill_idx;
    logic                mem_req;
    logic                mem_we;
    logic [c_ADDR_W-1:0] mem_addr;
    logic                mem_ack;
    logic                err;
    logic [15:0]         miss_count;

    dmem_miss_ctrl dut (
        .clk(clk), .rst_n(rst_n), .dm_read(dm_read), .dm_write(dm_write),
        .addr(addr), .wdata(wdata), .cache_hit(cache_hit),
        .victim_dirty(victim_dirty), .victim_tag(victim_tag), .stall(stall),
        .lat_addr(lat_addr), .rd_valid(rd_valid), .cache_we(cache_we),
        .cache_wdata(cache_wdata), .fill_we(fill_we), .fill_idx(fill_idx),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_ack(mem_ack), .err(err), .miss_count(miss_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          kind;
        logic [31:0] val;
    } evt_t;

    evt_t exp_q[$];
    int   n_tests   = 0;
    int   n_fail    = 0;
    int   fill_seen = 0;
    bit   ack_en    = 1'b1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push(input int k, input logic [31:0] v);
        evt_t e;
        e.kind = k;
        e.val  = v;
        exp_q.push_back(e);
    endtask

    task automatic got_evt(input int k, input logic [31:0] v);
        evt_t e;
        n_tests++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_event: got kind %0d val %h expected none", k, v);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != k || e.val !== v) begin
                n_fail++;
                $display("FAIL event: got kind %0d val %h expected kind %0d val %h",
                         k, v, e.kind, e.val);
            end
        end
    endtask

    task automatic push_fill(input logic [15:0] base);
        for (int i = 0; i < 4; i++) begin
            push(K_MRD, 32'(base + 16'(i * 4)));
            push(K_FIL, 32'(i));
        end
    endtask

    task automatic push_wb(input logic [15:0] base);
        for (int i = 0; i < 4; i++)
            push(K_MWB, 32'(base + 16'(i * 4)));
    endtask

    // Monitor: turns every visible DUT action into an event and scores it.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (rst_n) begin
                if (mem_req && mem_ack) got_evt(mem_we ? K_MWB : K_MRD, 32'(mem_addr));
                if (fill_we) begin
                    got_evt(K_FIL, 32'(fill_idx));
                    fill_seen++;
                end
                if (rd_valid) got_evt(K_RD, 32'(lat_addr));
                if (cache_we) got_evt(K_WR, cache_wdata);
            end
        end
    end

    // Memory model: acknowledges each word two cycles after the request is seen.
    initial begin
        int wcnt;
        wcnt    = 0;
        mem_ack = 1'b0;
        forever begin
            @(negedge clk);
            if (!ack_en) begin
                wcnt = 0;
            end else if (mem_ack) begin
                mem_ack = 1'b0;
                wcnt    = 0;
            end else if (mem_req) begin
                if (wcnt == 2) begin
                    mem_ack = 1'b1;
                    wcnt    = 0;
                end else begin
                    wcnt++;
                end
            end else begin
                wcnt = 0;
            end
        end
    end

    task automatic issue(input bit w, input logic [15:0] a, input logic [31:0] d);
        @(negedge clk);
        dm_read  = !w;
        dm_write = w;
        addr     = a;
        wdata    = d;
        #1;
        check("stall_on_request", 32'(stall), 32'd1);
        @(posedge clk);
        #1;
        dm_read  = 1'b0;
        dm_write = 1'b0;
        addr     = 16'hFFFF;
        wdata    = 32'h0;
    endtask

    // Counts stalled cycles (including the request cycle) until release, then steps to IDLE.
    task automatic wait_done(input bit hit_after, output int n);
        n = 1;
        while (stall && n < 300) begin
            @(posedge clk);
            #1;
            n++;
            if (fill_seen >= 4) cache_hit = hit_after;
        end
        check("stall_release_timeout", 32'(stall), 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst_n        = 1'b0;
        dm_read      = 1'b0;
        dm_write     = 1'b0;
        addr         = '0;
        wdata        = '0;
        cache_hit    = 1'b0;
        victim_dirty = 1'b0;
        victim_tag   = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_stall", 32'(stall), 32'd0);
        check("rst_mem_req", 32'(mem_req), 32'd0);
        check("rst_miss_count", 32'(miss_count), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_lat_addr", 32'(lat_addr), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Read hit
        cache_hit = 1'b1;
        fill_seen = 0;
        push(K_RD, 32'h0124);
        issue(1'b0, 16'h0124, 32'h0);
        wait_done(1'b1, n);
        check("read_hit_stall_cycles", 32'(n), 32'd2);
        check("read_hit_miss_count", 32'(miss_count), 32'd0);

        // Store hit
        push(K_WR, 32'h12345678);
        issue(1'b1, 16'h0200, 32'h12345678);
        wait_done(1'b1, n);
        check("store_hit_stall_cycles", 32'(n), 32'd2);

        // Clean read miss
        cache_hit    = 1'b0;
        victim_dirty = 1'b0;
        fill_seen    = 0;
        push_fill(16'h0120);
        push(K_RD, 32'h0124);
        issue(1'b0, 16'h0124, 32'h0);
        wait_done(1'b1, n);
        check("clean_miss_count", 32'(miss_count), 32'd1);

        // Dirty store miss
        cache_hit    = 1'b0;
        victim_dirty = 1'b1;
        victim_tag   = 8'h3A;
        fill_seen    = 0;
        push_wb(16'h3A20);
        push_fill(16'h0120);
        push(K_WR, 32'hDEADBEEF);
        issue(1'b1, 16'h0128, 32'hDEADBEEF);
        wait_done(1'b1, n);
        check("dirty_miss_count", 32'(miss_count), 32'd2);
        victim_dirty = 1'b0;

        // Reset in the middle of a refill
        cache_hit = 1'b0;
        fill_seen = 0;
        push(K_MRD, 32'h0120);
        push(K_FIL, 32'd0);
        push(K_MRD, 32'h0124);
        push(K_FIL, 32'd1);
        issue(1'b0, 16'h0124, 32'h0);
        n = 0;
        while (fill_seen < 2 && n < 300) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("second_fill_timeout", 32'(fill_seen), 32'd2);
        ack_en  = 1'b0;
        mem_ack = 1'b0;
        rst_n   = 1'b0;
        #1;
        check("midrst_stall", 32'(stall), 32'd0);
        check("midrst_mem_req", 32'(mem_req), 32'd0);
        check("midrst_fill_we", 32'(fill_we), 32'd0);
        check("midrst_miss_count", 32'(miss_count), 32'd0);
        check("midrst_pending_events", 32'(exp_q.size()), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        mem_ack = 1'b1;
        #1;
        check("late_ack_stall", 32'(stall), 32'd0);
        check("late_ack_mem_req", 32'(mem_req), 32'd0);
        @(negedge clk);
        mem_ack = 1'b0;
        ack_en  = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst_stall", 32'(stall), 32'd0);

        cache_hit = 1'b1;
        fill_seen = 0;
        push(K_RD, 32'h0300);
        issue(1'b0, 16'h0300, 32'h0);
        wait_done(1'b1, n);
        check("post_rst_hit_cycles", 32'(n), 32'd2);

        // Refill that still misses
        cache_hit = 1'b0;
        fill_seen = 0;
        push_fill(16'h0120);
        issue(1'b0, 16'h0124, 32'h0);
        wait_done(1'b0, n);
        check("err_set", 32'(err), 32'd1);
        check("err_miss_count", 32'(miss_count), 32'd1);

        cache_hit = 1'b1;
        fill_seen = 0;
        push(K_RD, 32'h0124);
        issue(1'b0, 16'h0124, 32'h0);
        wait_done(1'b1, n);
        check("err_sticky", 32'(err), 32'd1);
        check("after_err_hit_cycles", 32'(n), 32'd2);

        repeat (3) @(posedge clk);
        check("final_pending_events", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
